// File: rtl/event_frame_accumulator_pkg.sv
// grid_pkg: shared constants, types and helpers for the event frame accumulator.
//   GRID_SIZE/GRID_BITS : grid geometry (16 cells per axis, 4-bit axis index)
//   CELLS               : cells per frame bank
//   CNT_BITS            : signed saturating cell counter width
//   pos_to_idx          : signed grid position -> clamped 4-bit unsigned index
//   rd_state_t          : readout FSM states
package grid_pkg;

  localparam int GRID_SIZE = 16;
  localparam int GRID_BITS = 4;
  localparam int CELLS     = GRID_SIZE * GRID_SIZE;
  localparam int CNT_BITS  = 8;

  typedef logic signed [GRID_BITS:0]  grid_pos_t;
  typedef logic        [7:0]          cell_addr_t;
  typedef logic signed [CNT_BITS-1:0] cell_cnt_t;

  typedef enum logic [0:0] {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

  localparam cell_cnt_t CNT_MAX = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam cell_cnt_t CNT_MIN = {1'b1, {(CNT_BITS-1){1'b0}}};

  // Positions outside [-8,+7] pin to the nearest edge; in range, index = pos + 8.
  function automatic logic [GRID_BITS-1:0] pos_to_idx(input grid_pos_t pos);
    logic [GRID_BITS-1:0] idx;
    if (pos > 5'sd7) begin
      idx = 4'd15;
    end else if (pos < -5'sd8) begin
      idx = 4'd0;
    end else begin
      idx = 4'(pos + 5'sd8);
    end
    return idx;
  endfunction

endpackage

// File: rtl/event_frame_accumulator_if.sv
// event_frame_accumulator_if: event input and frame readout stream.
//   in_valid/in_x/in_y/in_polarity : one grid event per cycle, no backpressure
//   out_valid/out_ready            : readout handshake
//   out_data/out_addr/out_last     : signed cell count, cell index, last-cell flag
// master = producer of events / consumer of the stream; slave = the accumulator.
interface event_frame_accumulator_if;
  import grid_pkg::*;

  logic       in_valid;
  grid_pos_t  in_x;
  grid_pos_t  in_y;
  logic       in_polarity;
  logic       out_valid;
  logic       out_ready;
  cell_cnt_t  out_data;
  cell_addr_t out_addr;
  logic       out_last;

  modport master (
    output in_valid, in_x, in_y, in_polarity, out_ready,
    input  out_valid, out_data, out_addr, out_last
  );

  modport slave (
    input  in_valid, in_x, in_y, in_polarity, out_ready,
    output out_valid, out_data, out_addr, out_last
  );

endinterface

// File: rtl/event_frame_accumulator_sat.sv
// sat_updown: combinational signed +1/-1 on a cell counter, saturating at the
// counter's most positive / most negative value instead of wrapping.
//   value  : current count
//   up     : 1 = increment, 0 = decrement
//   result : updated count
module sat_updown
  import grid_pkg::*;
(
  input  cell_cnt_t value,
  input  logic      up,
  output cell_cnt_t result
);

  // Step toward the requested direction unless already pinned at that rail.
  always_comb begin
    result = value;
    if (up) begin
      if (value != CNT_MAX) begin
        result = value + 8'sd1;
      end else begin
        result = value;
      end
    end else begin
      if (value != CNT_MIN) begin
        result = value - 8'sd1;
      end else begin
        result = value;
      end
    end
  end

endmodule

// File: rtl/event_frame_accumulator.sv
// event_frame_accumulator: accumulates signed polarity counts of grid events into a
// 16x16 frame over a fixed window; two banks ping-pong so one accumulates while the
// other streams out row-major and is cleared as each cell is accepted.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : event input and readout stream
//   frame_overrun : sticky, a window ended while the readout was still busy
//   frame_count   : frames handed to the readout, wraps
module event_frame_accumulator
  import grid_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  event_frame_accumulator_if.slave   bus,
  output logic                       frame_overrun,
  output logic [15:0]                frame_count
);

  localparam int WIN_BITS = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_BITS-1:0] WIN_LAST = WIN_BITS'(WINDOW_CYCLES - 1);

  cell_cnt_t            bank_r [2][CELLS];
  logic                 acc_sel_r;
  logic [WIN_BITS-1:0]  win_cnt_r;
  rd_state_t            state_r;
  rd_state_t            state_nxt_s;
  cell_addr_t           rd_ptr_r;
  logic                 overrun_r;
  logic [15:0]          frame_cnt_r;

  logic                 terminal_s;
  logic                 swap_s;
  logic                 handshake_s;
  cell_addr_t           wr_addr_s;
  cell_cnt_t            acc_cur_s;
  cell_cnt_t            acc_upd_s;

  assign wr_addr_s   = {pos_to_idx(bus.in_y), pos_to_idx(bus.in_x)};
  assign acc_cur_s   = bank_r[acc_sel_r][wr_addr_s];
  assign terminal_s  = (win_cnt_r == WIN_LAST);
  // A window only closes into the readout when the previous frame is fully drained.
  assign swap_s      = terminal_s && (state_r == RD_IDLE);
  assign handshake_s = (state_r == RD_STREAM) && bus.out_ready;

  sat_updown u_sat (
    .value  (acc_cur_s),
    .up     (bus.in_polarity),
    .result (acc_upd_s)
  );

  // Free-running window counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_r <= '0;
    end else if (terminal_s) begin
      win_cnt_r <= '0;
    end else begin
      win_cnt_r <= win_cnt_r + 1'b1;
    end
  end

  // Bank select, frame counter and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_sel_r   <= 1'b0;
      frame_cnt_r <= 16'd0;
      overrun_r   <= 1'b0;
    end else begin
      if (swap_s) begin
        acc_sel_r   <= !acc_sel_r;
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      if (terminal_s && (state_r != RD_IDLE)) begin
        overrun_r <= 1'b1;
      end
    end
  end

  // Bank storage: single-cycle read-modify-write into the accumulate bank, and
  // clear-on-accept in the readout bank. The two never address the same bank, and
  // an event on the closing cycle still lands in the bank about to be streamed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < CELLS; c++) begin
          bank_r[b][c] <= '0;
        end
      end
    end else begin
      if (bus.in_valid) begin
        bank_r[acc_sel_r][wr_addr_s] <= acc_upd_s;
      end
      if (handshake_s) begin
        bank_r[!acc_sel_r][rd_ptr_r] <= '0;
      end
    end
  end

  // Readout FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RD_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Readout FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RD_IDLE: begin
        if (swap_s) begin
          state_nxt_s = RD_STREAM;
        end else begin
          state_nxt_s = RD_IDLE;
        end
      end
      RD_STREAM: begin
        if (handshake_s && (rd_ptr_r == 8'd255)) begin
          state_nxt_s = RD_IDLE;
        end else begin
          state_nxt_s = RD_STREAM;
        end
      end
      default: state_nxt_s = RD_IDLE;
    endcase
  end

  // Read pointer; the 8-bit wrap after cell 255 returns it to 0 for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= 8'd0;
    end else if (handshake_s) begin
      rd_ptr_r <= rd_ptr_r + 8'd1;
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  // Readout FSM outputs, decoded from registered state and pointer.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    bus.out_addr  = rd_ptr_r;
    case (state_r)
      RD_IDLE: begin
        bus.out_valid = 1'b0;
      end
      RD_STREAM: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (rd_ptr_r == 8'd255);
        bus.out_data  = bank_r[!acc_sel_r][rd_ptr_r];
      end
      default: begin
        bus.out_valid = 1'b0;
      end
    endcase
  end

  assign frame_overrun = overrun_r;
  assign frame_count   = frame_cnt_r;

endmodule

// File: tb/tb_event_frame_accumulator.sv
// Bench for event_frame_accumulator with a 64-cycle window. A frame-level model
// (an accumulating frame, a readout frame, a cursor) is stepped once per clock and
// every DUT output is compared against it; directed scenarios add explicit
// expectations on the captured frames.
module tb_event_frame_accumulator;
  import grid_pkg::*;

  localparam int W = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_overrun;
  logic [15:0] frame_count;

  event_frame_accumulator_if bus();

  event_frame_accumulator #(.WINDOW_CYCLES(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .frame_overrun (frame_overrun),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_acc [256];
  int m_rd  [256];
  bit m_stream;
  int m_ptr;
  int m_pos;
  int m_fcnt;
  bit m_ovr;
  int seen  [256];
  int last_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < -8) return 0;
    if (v > 7) return 15;
    return v + 8;
  endfunction

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_acc[i] = 0;
      m_rd[i]  = 0;
    end
    m_stream = 1'b0;
    m_ptr = 0;
    m_pos = 0;
    m_fcnt = 0;
    m_ovr = 1'b0;
  endtask

  task automatic check_outputs();
    chk("out_valid", int'(bus.out_valid), int'(m_stream));
    chk("out_addr", int'(bus.out_addr), m_ptr);
    chk("out_data", int'(bus.out_data), m_stream ? m_rd[m_ptr] : 0);
    chk("out_last", int'(bus.out_last), int'(m_stream && m_ptr == 255));
    chk("frame_count", int'(frame_count), m_fcnt);
    chk("frame_overrun", int'(frame_overrun), int'(m_ovr));
    if (bus.out_valid === 1'b1) begin
      seen[bus.out_addr] = int'(bus.out_data);
      if (bus.out_last === 1'b1) last_cnt++;
    end
  endtask

  // One clock: compare current outputs, apply inputs, advance model, clock.
  task automatic tick(input bit r, input bit v, input int x, input int y,
                      input bit p, input bit rdy);
    bit busy;
    int idx;
    int tmp [256];
    check_outputs();
    rst             = r;
    bus.in_valid    = v;
    bus.in_x        = grid_pos_t'(x);
    bus.in_y        = grid_pos_t'(y);
    bus.in_polarity = p;
    bus.out_ready   = rdy;
    if (r) begin
      model_reset();
    end else begin
      busy = m_stream;
      if (v) begin
        idx = clampi(y) * 16 + clampi(x);
        m_acc[idx] = sat(m_acc[idx] + (p ? 1 : -1));
      end
      if (busy && rdy) begin
        m_rd[m_ptr] = 0;
        if (m_ptr == 255) begin
          m_stream = 1'b0;
          m_ptr = 0;
        end else begin
          m_ptr++;
        end
      end
      if (m_pos == W - 1) begin
        if (!busy) begin
          tmp = m_rd;
          m_rd = m_acc;
          m_acc = tmp;
          m_stream = 1'b1;
          m_fcnt = (m_fcnt + 1) % 65536;
        end else begin
          m_ovr = 1'b1;
        end
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Idle with ready=1 until a frame has started and fully drained; record cells.
  task automatic capture_frame();
    bit started;
    started = 1'b0;
    last_cnt = 0;
    for (int i = 0; i < 256; i++) seen[i] = -999;
    for (int n = 0; n < 2000; n++) begin
      if (m_stream) started = 1'b1;
      if (started && !m_stream) break;
      tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    end
    chk("frame_done", int'(started && !m_stream), 1);
  endtask

  // Compare a captured frame: two named cells, every other cell must be zero.
  task automatic chk_frame(input string tag, input int a1, input int v1,
                           input int a2, input int v2);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i != a1 && i != a2 && seen[i] != 0) bad++;
    end
    if (a1 >= 0) chk({tag, "_cell_a"}, seen[a1], v1);
    if (a2 >= 0) chk({tag, "_cell_b"}, seen[a2], v2);
    chk({tag, "_other_cells"}, bad, 0);
    chk({tag, "_last_count"}, last_cnt, 1);
  endtask

  task automatic wait_stream_start();
    for (int n = 0; n < 200 && !m_stream; n++) tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("stream_start", int'(m_stream), 1);
  endtask

  // Stall the readout while injecting n events at (0,0).
  task automatic stall_inject(input int n, input bit pol);
    int fc0;
    fc0 = int'(frame_count);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 0, 0, pol, 1'b0);
    chk("stall_valid_held", int'(bus.out_valid), 1);
    chk("stall_addr_held", int'(bus.out_addr), 0);
    chk("stall_overrun", int'(frame_overrun), 1);
    chk("stall_fcnt_same", int'(frame_count), fc0);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_y = '0;
    bus.in_polarity = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Basic frame: corners of the grid.
    tick(1'b0, 1'b1, -8, -8, 1'b1, 1'b1);
    tick(1'b0, 1'b1, -8, -8, 1'b1, 1'b1);
    tick(1'b0, 1'b1, -8, -8, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 7, 7, 1'b0, 1'b1);
    capture_frame();
    chk_frame("corners", 0, 3, 255, -1);
    chk("corners_fcnt", int'(frame_count), 1);

    // Saturation with a stalled readout (windows merge, overrun set).
    tick(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("rst_overrun_clear", int'(frame_overrun), 0);
    wait_stream_start();
    stall_inject(200, 1'b1);
    capture_frame();
    wait_stream_start();
    stall_inject(200, 1'b0);
    capture_frame();
    chk_frame("sat_pos", 136, 127, -1, 0);
    capture_frame();
    chk_frame("sat_neg", 136, -128, -1, 0);

    // Event on the terminal-count cycle goes into the closing frame.
    for (int n = 0; n < 500 && !(m_pos == W - 1 && !m_stream); n++)
      tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("term_aligned", m_pos, W - 1);
    tick(1'b0, 1'b1, 1, 2, 1'b1, 1'b1);
    capture_frame();
    chk_frame("term_event", 169, 1, -1, 0);
    capture_frame();
    chk_frame("cleared", -1, 0, -1, 0);

    // Reset in the middle of a stream, then clamped inputs.
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 3, 3, 1'b1, 1'b1);
    wait_stream_start();
    for (int n = 0; n < 300 && m_ptr != 50; n++) tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("rst_at_cell50", int'(bus.out_addr), 50);
    tick(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("rst_valid_low", int'(bus.out_valid), 0);
    tick(1'b0, 1'b1, 9, 0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, -12, 3, 1'b0, 1'b1);
    capture_frame();
    chk_frame("post_rst_clamp", 143, 1, 176, -1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 31) - 16,
           $urandom_range(0, 31) - 16, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0);
    end
    tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
